// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and word helpers for the key schedule.
// Words are numbered w0..w3 from the most significant end (text byte order).
package aes_pkg;

   localparam logic [3:0] NR = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      EMIT
   } state_t;

   // Round constant already placed in the most significant byte of a word.
   function automatic logic [31:0] rcon(input logic [3:0] r);
      logic [7:0] b;
      case (r)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

   function automatic logic [31:0] word_of(input logic [127:0] k, input logic [1:0] i);
      logic [31:0] w;
      case (i)
         2'd0:    w = k[127:96];
         2'd1:    w = k[95:64];
         2'd2:    w = k[63:32];
         default: w = k[31:0];
      endcase
      return w;
   endfunction

   function automatic logic [127:0] join_words(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w2, input logic [31:0] w3);
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Shared by the key schedule SubWord bank and any SubBytes datapath.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = SBOX[a];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption round keys: expand forward to key 10, then walk back to key 0 one per handshake.
// First key valid 10 cycles after start; outputs hold while round_key_valid && !round_key_ready.
module aes_inv_key_schedule
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         round_key_valid,
   input  logic         round_key_ready,
   output logic         done
);

   state_t       state, state_nxt;
   logic [127:0] key_q, key_nxt;
   logic [3:0]   rnd, rnd_nxt;
   logic         done_nxt;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sbox_in, rot, sub_word, rc;
   logic [3:0]   rcon_idx;
   logic [31:0]  f0, f1, f2, f3;
   logic [31:0]  b0, b1, b2, b3;

   assign w0 = word_of(key_q, 2'd0);
   assign w1 = word_of(key_q, 2'd1);
   assign w2 = word_of(key_q, 2'd2);
   assign w3 = word_of(key_q, 2'd3);

   // One SubWord bank: the backward step needs the already-recovered w3, i.e. w3 ^ w2.
   assign sbox_in  = (state == EMIT) ? (w3 ^ w2) : w3;
   assign rot      = rot_word(sbox_in);
   assign rcon_idx = (state == EXPAND) ? (rnd + 4'd1) : rnd;
   assign rc       = rcon(rcon_idx);

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .a (rot[8*i +: 8]),
         .y (sub_word[8*i +: 8])
      );
   end

   assign f0 = w0 ^ sub_word ^ rc;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;

   assign b3 = w3 ^ w2;
   assign b2 = w2 ^ w1;
   assign b1 = w1 ^ w0;
   assign b0 = w0 ^ sub_word ^ rc;

   always_comb begin
      state_nxt = state;
      key_nxt   = key_q;
      rnd_nxt   = rnd;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               key_nxt   = key_in;
               rnd_nxt   = 4'd0;
               state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            key_nxt = join_words(f0, f1, f2, f3);
            rnd_nxt = rnd + 4'd1;
            if (rnd == NR - 4'd1) begin
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (round_key_ready) begin
               if (rnd != 4'd0) begin
                  key_nxt = join_words(b0, b1, b2, b3);
                  rnd_nxt = rnd - 4'd1;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         key_q <= '0;
         rnd   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         key_q <= key_nxt;
         rnd   <= rnd_nxt;
         done  <= done_nxt;
      end
   end

   assign busy            = (state != IDLE);
   assign round_key       = key_q;
   assign round_num       = rnd;
   assign round_key_valid = (state == EMIT);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule using FIPS-197 and all-zero keys.
// Edge counts are measured from the edge that samples start.
module tb_aes_inv_key_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic [127:0] round_key;
   logic [3:0]   round_num;
   logic         round_key_valid;
   logic         round_key_ready;
   logic         done;

   int checks   = 0;
   int failures = 0;
   int edges    = 0;

   logic [127:0] exp_keys  [0:10];
   bit           exp_known [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_inv_key_schedule dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .key_in          (key_in),
      .busy            (busy),
      .round_key       (round_key),
      .round_num       (round_num),
      .round_key_valid (round_key_valid),
      .round_key_ready (round_key_ready),
      .done            (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_fips();
      exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_keys[0]  = FIPS_KEY;
      for (int i = 0; i <= 10; i++) exp_known[i] = 1'b1;
   endtask

   task automatic load_zero();
      for (int i = 0; i <= 10; i++) begin
         exp_known[i] = 1'b0;
         exp_keys[i]  = '0;
      end
      exp_keys[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
      exp_known[10] = 1'b1;
      exp_known[0]  = 1'b1;
   endtask

   // One full schedule; poke drives stray start pulses during EXPAND, mid-EMIT and on the last handshake.
   task automatic run_sched(input logic [127:0] key, input int stall_at, input int stall_len, input bit poke);
      round_key_ready = 1'b1;
      key_in = key;
      start  = 1'b1;
      tick();
      edges  = 0;
      start  = 1'b0;
      while (!round_key_valid && edges < 40) begin
         start = poke && (edges == 3);
         if (start) key_in = ~key;
         tick();
         start = 1'b0;
      end
      check("first_valid_edge", 128'(edges), 128'd10);
      for (int r = 10; r >= 0; r--) begin
         if (r == stall_at) begin
            round_key_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               check("stall_num", 128'(round_num), 128'(r));
               check("stall_key", round_key, exp_keys[r]);
            end
            round_key_ready = 1'b1;
         end
         check("valid", 128'(round_key_valid), 128'd1);
         check("round_num", 128'(round_num), 128'(r));
         if (exp_known[r]) check("round_key", round_key, exp_keys[r]);
         if (poke && (r == 5 || r == 0)) begin
            start  = 1'b1;
            key_in = ~key;
         end
         tick();
         start = 1'b0;
      end
      check("done_pulse", 128'(done), 128'd1);
      check("done_busy", 128'(busy), 128'd0);
      check("done_edge", 128'(edges), 128'(21 + stall_len));
      tick();
      check("done_once", 128'(done), 128'd0);
      check("idle_after", 128'(busy), 128'd0);
   endtask

   initial begin
      rst             = 1'b1;
      start           = 1'b0;
      key_in          = '0;
      round_key_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_valid", 128'(round_key_valid), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_key", round_key, 128'd0);
      check("rst_num", 128'(round_num), 128'd0);

      // Plain FIPS-197 walk with ready held high.
      load_fips();
      run_sched(FIPS_KEY, -1, 0, 1'b0);

      // Five-cycle stall at round 7.
      run_sched(FIPS_KEY, 7, 5, 1'b0);

      // Stray starts must not disturb the sequence.
      run_sched(FIPS_KEY, -1, 0, 1'b1);

      // Reset while round 4 is presented.
      round_key_ready = 1'b1;
      key_in = FIPS_KEY;
      start  = 1'b1;
      tick();
      edges  = 0;
      start  = 1'b0;
      while (!(round_key_valid && round_num == 4'd4) && edges < 60) tick();
      check("pre_rst_num", 128'(round_num), 128'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", 128'(busy), 128'd0);
      check("mid_rst_valid", 128'(round_key_valid), 128'd0);
      check("mid_rst_done", 128'(done), 128'd0);
      check("mid_rst_key", round_key, 128'd0);
      check("mid_rst_num", 128'(round_num), 128'd0);
      tick();
      check("post_rst_done", 128'(done), 128'd0);
      run_sched(FIPS_KEY, -1, 0, 1'b0);

      // start held high: restart on the edge after the done cycle.
      key_in = FIPS_KEY;
      start  = 1'b1;
      tick();
      edges  = 0;
      while (!done && edges < 60) tick();
      check("b2b_done_edge", 128'(edges), 128'd21);
      check("b2b_done_busy", 128'(busy), 128'd0);
      tick();
      check("b2b_restart_busy", 128'(busy), 128'd1);
      start = 1'b0;
      edges = 0;
      while (!round_key_valid && edges < 40) tick();
      check("b2b_valid_edge", 128'(edges), 128'd10);
      check("b2b_key10", round_key, exp_keys[10]);
      edges = 0;
      while (!done && edges < 40) tick();
      check("b2b_second_done", 128'(done), 128'd1);
      tick();

      // All-zero key.
      load_zero();
      run_sched(128'd0, -1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
